// File: rtl/collector_pkg.sv
// Shared constants and state encoding for the systolic result collector.
// Default N/Ba/IDXW match the perceptron engine build.
package collector_pkg;

  localparam int N_DEF    = 40;
  localparam int BA_DEF   = 24;
  localparam int IDXW_DEF = 6;
  localparam int LAT_DEF  = 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DRAIN   = 2'd2
  } state_t;

endpackage

// File: rtl/collector_buf.sv
// N x Ba result register file: one write port, one registered read port.
// Ports: clk, rst (async low), wr_en/wr_idx/wr_data, rd_en/rd_idx -> rd_data.
module collector_buf
  import collector_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int Ba   = BA_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic [IDXW-1:0] wr_idx,
  input  logic [Ba-1:0]   wr_data,
  input  logic            rd_en,
  input  logic [IDXW-1:0] rd_idx,
  output logic [Ba-1:0]   rd_data
);

  logic [Ba-1:0] mem [N];

  // Contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: rtl/result_collector.sv
// De-skews the engine's lane wavefront into a buffer and streams it out
// one lane per valid/ready beat in lane order.
// Ports: clk, rst (async low), out_bus, stop in; res_data/res_idx/
// res_valid out, res_ready in; busy, overrun (sticky) out.
// Option COLLECT_LAST_EN adds res_last, high on the idx N-1 beat.
module result_collector
  import collector_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int Ba   = BA_DEF,
  parameter int LAT  = LAT_DEF,
  parameter int IDXW = IDXW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N*Ba-1:0] out_bus,
  input  logic            stop,
  output logic [Ba-1:0]   res_data,
  output logic [IDXW-1:0] res_idx,
  output logic            res_valid,
  input  logic            res_ready,
  output logic            busy,
  output logic            overrun
`ifdef COLLECT_LAST_EN
  ,
  output logic            res_last
`endif
);

  localparam int CW = IDXW + 1;
  localparam int DW = 4;

  localparam logic [CW-1:0]   ONE_C    = CW'(1);
  localparam logic [CW-1:0]   LAST_C   = CW'(N - 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);
  localparam logic [DW-1:0]   LAT_C    = DW'(LAT);
  localparam logic [DW-1:0]   DONE_C   = DW'(1);

  state_t          state_q;
  state_t          state_n;
  logic [DW-1:0]   dcnt_q;
  logic [DW-1:0]   dcnt_n;
  logic [CW-1:0]   wr_cnt_q;
  logic [CW-1:0]   wr_cnt_n;
  logic [CW-1:0]   rd_idx_q;
  logic [CW-1:0]   rd_idx_n;
  logic            stop_q;
  logic            valid_q;
  logic            valid_n;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] idx_n;
  logic            over_q;
  logic            over_n;
`ifdef COLLECT_LAST_EN
  logic            last_q;
  logic            last_n;
`endif

  logic            rise;
  logic            accept;
  logic            cap;
  logic            cap_ok;
  logic            load;
  logic [DW-1:0]   dnext;
  logic            wr_en;
  logic            rd_en;
  logic [IDXW-1:0] wr_idx;
  logic [Ba-1:0]   wr_data;

  logic [Ba-1:0] lane [N];

  for (genvar k = 0; k < N; k++) begin : g_lane
    assign lane[k] = out_bus[k*Ba +: Ba];
  end

  assign rise    = stop & ~stop_q;
  assign accept  = valid_q & res_ready;
  assign dnext   = dcnt_q + DONE_C;
  assign cap_ok  = dnext >= LAT_C;
  assign wr_idx  = wr_cnt_q[IDXW-1:0];
  assign wr_data = lane[wr_idx];

  always_comb begin
    state_n  = state_q;
    dcnt_n   = dcnt_q;
    wr_cnt_n = wr_cnt_q;
    rd_idx_n = rd_idx_q;
    valid_n  = valid_q;
    idx_n    = idx_q;
    over_n   = over_q;
`ifdef COLLECT_LAST_EN
    last_n   = last_q;
`endif
    cap      = 1'b0;
    load     = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;

    // A fresh stop edge while a frame is in flight is dropped.
    if (state_q != ST_IDLE && rise) begin
      over_n = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_n = ST_CAPTURE;
          dcnt_n  = '0;
          // Zero latency: lane 0 is already stable on this edge.
          cap     = (LAT == 0);
        end
      end
      ST_CAPTURE: begin
        if (cap_ok) begin
          cap = 1'b1;
        end else begin
          dcnt_n = dnext;
        end
      end
      ST_DRAIN: begin
        if (accept && idx_q == LAST_IDX) begin
          state_n  = ST_IDLE;
          wr_cnt_n = '0;
          rd_idx_n = '0;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // wr_cnt tracks the lane the wavefront reaches this edge.
    if (cap) begin
      wr_en    = 1'b1;
      wr_cnt_n = wr_cnt_q + ONE_C;
      if (wr_cnt_q == LAST_C) begin
        state_n = ST_DRAIN;
      end
    end

    // Refill the output stage as soon as it is empty or being taken.
    load = (rd_idx_q < wr_cnt_q) && (!valid_q || res_ready);
    if (load) begin
      rd_en    = 1'b1;
      valid_n  = 1'b1;
      idx_n    = rd_idx_q[IDXW-1:0];
      rd_idx_n = rd_idx_q + ONE_C;
`ifdef COLLECT_LAST_EN
      last_n   = (rd_idx_q == LAST_C);
`endif
    end else if (accept) begin
      valid_n  = 1'b0;
`ifdef COLLECT_LAST_EN
      last_n   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      dcnt_q   <= '0;
      wr_cnt_q <= '0;
      rd_idx_q <= '0;
      stop_q   <= 1'b0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      over_q   <= 1'b0;
`ifdef COLLECT_LAST_EN
      last_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_n;
      dcnt_q   <= dcnt_n;
      wr_cnt_q <= wr_cnt_n;
      rd_idx_q <= rd_idx_n;
      stop_q   <= stop;
      valid_q  <= valid_n;
      idx_q    <= idx_n;
      over_q   <= over_n;
`ifdef COLLECT_LAST_EN
      last_q   <= last_n;
`endif
    end
  end

  collector_buf #(
    .N    (N),
    .Ba   (Ba),
    .IDXW (IDXW)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .rd_en   (rd_en),
    .rd_idx  (rd_idx_q[IDXW-1:0]),
    .rd_data (res_data)
  );

  assign res_idx   = idx_q;
  assign res_valid = valid_q;
  assign busy      = (state_q != ST_IDLE);
  assign overrun   = over_q;
`ifdef COLLECT_LAST_EN
  assign res_last  = last_q;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Randomized bench for result_collector against a frame-level model.
// Optional COLLECT_LAST_EN also checks res_last.
module tb_result_collector;

  localparam int N    = 40;
  localparam int BA   = 24;
  localparam int LAT  = 1;
  localparam int IDXW = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [N*BA-1:0] out_bus = '0;
  logic            stop = 1'b0;
  logic [BA-1:0]   res_data;
  logic [IDXW-1:0] res_idx;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic            busy;
  logic            overrun;
`ifdef COLLECT_LAST_EN
  logic            res_last;
`endif

  always #5 clk = ~clk;

  result_collector #(
    .N    (N),
    .Ba   (BA),
    .LAT  (LAT),
    .IDXW (IDXW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .out_bus   (out_bus),
    .stop      (stop),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .overrun   (overrun)
`ifdef COLLECT_LAST_EN
    ,
    .res_last  (res_last)
`endif
  );

  int total = 0;
  int bad   = 0;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame model: frame time t counts edges from the start edge.
  bit            m_act;
  int            m_t;
  int            m_acc;
  bit            m_stop_q;
  bit            m_over;
  logic [BA-1:0] exp_lane [N];
  logic [BA-1:0] val [N];
  bit            o_valid;
  logic [BA-1:0] o_data;
  logic [IDXW-1:0] o_idx;

  task automatic tick();
    bit rise;
    bit act0;
    bit ev;
    @(posedge clk);
    #1;
    rise = stop && !m_stop_q;
    m_stop_q = stop;
    act0 = m_act;
    if (rise && act0) m_over = 1'b1;
    if (o_valid && res_ready) begin
      if (m_acc < N) begin
        check("beat_idx", o_idx, m_acc);
        check("beat_data", o_data, exp_lane[m_acc]);
        m_acc++;
        if (m_acc == N) m_act = 1'b0;
      end else begin
        check("extra_beat", o_valid, 0);
      end
    end
    if (rise && !act0) begin
      m_act = 1'b1;
      m_t = 0;
      m_acc = 0;
    end else if (m_act) begin
      m_t++;
    end
    if (m_act && m_t >= LAT && m_t - LAT < N)
      exp_lane[m_t-LAT] = out_bus[(m_t-LAT)*BA +: BA];
    ev = m_act && m_acc < N && (LAT + m_acc + 1 <= m_t);
    check("valid", res_valid, ev);
    check("busy", busy, m_act);
    check("overrun", overrun, m_over);
    if (ev && res_valid) begin
      check("data", res_data, exp_lane[m_acc]);
      check("idx", res_idx, m_acc);
    end
`ifdef COLLECT_LAST_EN
    check("last", res_last, ev && m_acc == N - 1);
`endif
    o_valid = res_valid;
    o_data  = res_data;
    o_idx   = res_idx;
  endtask

  task automatic drive(int bm, int rm, int c, bit st);
    int tn;
    tn = m_act ? m_t + 1 : 0;
    stop = st;
    case (rm)
      0: res_ready = 1'b1;
      1: res_ready = (c % 4 == 0) || (c % 4 == 3);
      default: res_ready = 1'($urandom_range(0, 1));
    endcase
    for (int k = 0; k < N; k++) begin
      case (bm)
        0: out_bus[k*BA +: BA] = 24'h000100 + BA'(k);
        1: out_bus[k*BA +: BA] =
             (tn == LAT + k) ? val[k] : 24'hDEADBE;
        default: out_bus[k*BA +: BA] = BA'($urandom);
      endcase
    end
  endtask

  task automatic do_reset();
    stop = 1'b0;
    rst = 1'b0;
    #2;
    check("rst_valid", res_valid, 0);
    check("rst_data", res_data, 0);
    check("rst_idx", res_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_over", overrun, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_valid", res_valid, 0);
    check("rst_hold_busy", busy, 0);
    m_act = 0;
    m_over = 0;
    m_stop_q = 0;
    m_acc = 0;
    m_t = 0;
    o_valid = 0;
    rst = 1'b1;
  endtask

  task automatic run_frame(int bm, int rm, int slen,
                           int second, int rst_at);
    bit done;
    bit was_rst;
    done = 0;
    was_rst = 0;
    for (int k = 0; k < N; k++) begin
      val[k] = BA'($urandom);
      if (val[k] == 24'hDEADBE) val[k] ^= 24'h1;
    end
    for (int c = 0; c < 600; c++) begin
      bit st;
      st = (c < slen) || (m_act && m_t + 1 == second);
      drive(bm, rm, c, st);
      tick();
      if (rst_at >= 0 && m_act && m_t == rst_at) begin
        do_reset();
        done = 1;
        was_rst = 1;
        break;
      end
      if (c >= slen && !m_act) begin
        done = 1;
        break;
      end
    end
    check("frame_end", done, 1);
    if (!was_rst) check("beats", m_acc, N);
    for (int c = 0; c < 2; c++) begin
      drive(0, 2, c, 1'b0);
      tick();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    m_act = 0;
    m_t = 0;
    m_acc = 0;
    m_stop_q = 0;
    m_over = 0;
    o_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("init_valid", res_valid, 0);
    check("init_data", res_data, 0);
    check("init_idx", res_idx, 0);
    check("init_busy", busy, 0);
    check("init_over", overrun, 0);
`ifdef COLLECT_LAST_EN
    check("init_last", res_last, 0);
`endif
    rst = 1'b1;

    run_frame(0, 0, 1, -1, -1);
    run_frame(1, 0, 1, -1, -1);
    run_frame(2, 1, 1, -1, -1);
    run_frame(0, 0, 1, 10, -1);
    check("over_sticky", overrun, 1);
    run_frame(0, 0, 1, -1, 20);
    run_frame(1, 2, 2, -1, -1);
    check("over_cleared", overrun, 0);
    run_frame(0, 0, 1, LAT + N + 1, -1);
    check("over_at_end", overrun, 1);
    repeat (6) begin
      run_frame(int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)),
                int'($urandom_range(1, 4)), -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
